// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its requesters (LCD scan, MCU write, fill)
// and the single-ported frame-buffer RAM.
interface fb_port_arbiter_if #(
    parameter int DATAW = 6,
    parameter int ADDRW = 15
);
    logic             rd_valid;
    logic [ADDRW-1:0] rd_addr;
    logic             rd_ready;
    logic [DATAW-1:0] rd_data;
    logic             rd_data_valid;

    logic             wr_valid;
    logic [ADDRW-1:0] wr_addr;
    logic [DATAW-1:0] wr_data;
    logic             wr_ready;

    logic             fill_start;
    logic [DATAW-1:0] fill_color;
    logic             fill_busy;
    logic             fill_done;

    logic [ADDRW-1:0] ram_addr;
    logic [DATAW-1:0] ram_din;
    logic             ram_we;
    logic             ram_re;
    logic [DATAW-1:0] ram_dout;

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_color, ram_dout,
        output rd_ready, rd_data, rd_data_valid, wr_ready,
               fill_busy, fill_done, ram_addr, ram_din, ram_we, ram_re
    );

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_color, ram_dout,
        input  rd_ready, rd_data, rd_data_valid, wr_ready,
               fill_busy, fill_done, ram_addr, ram_din, ram_we, ram_re
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: LCD reads first, MCU writes / fill writes get a
// guaranteed slot after STARVE_LIMIT back-to-back reads.
module fb_port_arbiter #(
    parameter int DATAW        = 6,
    parameter int ADDRW        = 15,
    parameter int FILL_LAST    = 24191,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clock,
    input  logic               reset,
    fb_port_arbiter_if.slave   bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [7:0]       LP_STARVE    = 8'(STARVE_LIMIT);
    localparam logic [ADDRW-1:0] LP_FILL_LAST = ADDRW'(FILL_LAST);

    state_t           r_state;
    logic [7:0]       r_starve;
    logic [ADDRW-1:0] r_fill_cnt;
    logic [DATAW-1:0] r_fill_color;
    logic [ADDRW-1:0] r_ram_addr;
    logic [DATAW-1:0] r_ram_din;
    logic             r_ram_we;
    logic             r_ram_re;
    logic             r_re_d;
    logic [DATAW-1:0] r_rd_data;
    logic             r_rd_data_valid;
    logic             r_fill_busy;
    logic             r_fill_done;

    logic             w_low_pend;
    logic             w_under;
    logic             w_rd_grant;
    logic             w_low_grant;

    // Per-cycle grant decision; nothing is granted while reset is held low.
    always_comb begin
        w_low_pend  = 1'b0;
        w_under     = (r_starve < LP_STARVE);
        w_rd_grant  = 1'b0;
        w_low_grant = 1'b0;
        if (!reset) begin
            w_low_pend = 1'b0;
        end else begin
            w_low_pend = (r_state == ST_FILL) || bus.wr_valid;
            if (bus.rd_valid && w_under) begin
                w_rd_grant = 1'b1;
            end else if (w_low_pend) begin
                w_low_grant = 1'b1;
            end else if (bus.rd_valid) begin
                w_rd_grant = 1'b1;
            end else begin
                w_rd_grant = 1'b0;
            end
        end
    end

    assign bus.rd_ready      = w_rd_grant;
    assign bus.wr_ready      = w_low_grant && (r_state == ST_IDLE);
    assign bus.ram_addr      = r_ram_addr;
    assign bus.ram_din       = r_ram_din;
    assign bus.ram_we        = r_ram_we;
    assign bus.ram_re        = r_ram_re;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_data_valid;
    assign bus.fill_busy     = r_fill_busy;
    assign bus.fill_done     = r_fill_done;

    // RAM issue, read-return pipeline, starvation counter and IDLE/FILL state machine.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_starve        <= 8'd0;
            r_fill_cnt      <= '0;
            r_fill_color    <= '0;
            r_ram_addr      <= '0;
            r_ram_din       <= '0;
            r_ram_we        <= 1'b0;
            r_ram_re        <= 1'b0;
            r_re_d          <= 1'b0;
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
            r_fill_busy     <= 1'b0;
            r_fill_done     <= 1'b0;
        end else begin
            r_ram_we <= w_low_grant;
            r_ram_re <= w_rd_grant;
            if (w_rd_grant) begin
                r_ram_addr <= bus.rd_addr;
            end else if (w_low_grant && (r_state == ST_FILL)) begin
                r_ram_addr <= r_fill_cnt;
                r_ram_din  <= r_fill_color;
            end else if (w_low_grant) begin
                r_ram_addr <= bus.wr_addr;
                r_ram_din  <= bus.wr_data;
            end else begin
                r_ram_addr <= r_ram_addr;
            end

            // RAM output becomes valid the cycle after ram_re; capture it one edge later.
            r_re_d          <= r_ram_re;
            r_rd_data_valid <= r_re_d;
            if (r_re_d) begin
                r_rd_data <= bus.ram_dout;
            end else begin
                r_rd_data <= r_rd_data;
            end

            if (!w_low_pend) begin
                r_starve <= 8'd0;
            end else if (w_rd_grant) begin
                r_starve <= r_starve + 8'd1;
            end else if (w_low_grant) begin
                r_starve <= 8'd0;
            end else begin
                r_starve <= r_starve;
            end

            r_fill_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.fill_start) begin
                        r_state      <= ST_FILL;
                        r_fill_busy  <= 1'b1;
                        r_fill_color <= bus.fill_color;
                        r_fill_cnt   <= '0;
                    end else begin
                        r_fill_busy  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_low_grant && (r_fill_cnt == LP_FILL_LAST)) begin
                        r_state     <= ST_IDLE;
                        r_fill_busy <= 1'b0;
                        r_fill_done <= 1'b1;
                    end else if (w_low_grant) begin
                        r_fill_cnt  <= r_fill_cnt + {{(ADDRW-1){1'b0}}, 1'b1};
                    end else begin
                        r_fill_cnt  <= r_fill_cnt;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_fill_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: priority/starvation vector table plus reset,
// read-latency, fill, fill-with-reads and reset-mid-fill sequences against a RAM model.
module tb_fb_port_arbiter;
    localparam int DW = 6;
    localparam int AW = 15;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    fb_port_arbiter_if #(.DATAW(DW), .ADDRW(AW)) bus ();

    fb_port_arbiter #(.DATAW(DW), .ADDRW(AW), .FILL_LAST(24191), .STARVE_LIMIT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] mem [0:32767];

    // Frame-buffer RAM model with one cycle of read latency.
    always @(posedge clock) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        if (bus.ram_re) bus.ram_dout <= mem[bus.ram_addr];
    end

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] raddr;
        logic          exp_rd;
        logic          exp_wr;
    } vec_t;
    vec_t vq[$];

    logic [DW-1:0] expq[$];
    bit            mon_en;
    int            rbad;
    int            rets;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [AW-1:0] ra,
                       input logic erd, input logic ewr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.raddr = ra; v.exp_rd = erd; v.exp_wr = ewr;
        vq.push_back(v);
    endtask

    task automatic step();
        logic [DW-1:0] e;
        @(posedge clock);
        @(negedge clock);
        if (mon_en && bus.rd_data_valid) begin
            rets++;
            if (expq.size() == 0) rbad++;
            else begin
                e = expq.pop_front();
                if (bus.rd_data !== e) rbad++;
            end
        end
    endtask

    task automatic mem_chk(input string nm, input int lo, input int hi, input logic [DW-1:0] v);
        int bad;
        bad = 0;
        for (int a = lo; a <= hi; a++) if (mem[a] !== v) bad++;
        chk(nm, bad, 0);
    endtask

    initial begin
        int bad, cyc, n, rdy_bad;
        bit done, found;
        checks = 0; errors = 0; mon_en = 0; rbad = 0; rets = 0;

        // Priority / starvation table, wr_addr 0x0010 wr_data 0x15 throughout.
        add(0, 0, 15'h0000, 0, 0);
        add(0, 1, 15'h0000, 0, 1);
        add(1, 0, 15'h0200, 1, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 15'(16'h0300 + i), 1, 0);
        add(1, 1, 15'h0308, 0, 1);
        for (int i = 0; i < 8; i++) add(1, 1, 15'(16'h0400 + i), 1, 0);
        add(1, 1, 15'h0408, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 15'(16'h0500 + i), 1, 0);
        add(1, 0, 15'h0600, 1, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 15'(16'h0700 + i), 1, 0);
        add(1, 1, 15'h0708, 0, 1);
        add(1, 1, 15'h0709, 1, 0);

        // Reset held 3 cycles with every valid high.
        reset = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 15'h0055;
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h0066; bus.wr_data = 6'h01;
        bus.fill_start = 1'b0; bus.fill_color = 6'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rd_ready", bus.rd_ready, 0);
            chk("rst_wr_ready", bus.wr_ready, 0);
        end
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_din", bus.ram_din, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_re", bus.ram_re, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_data_valid", bus.rd_data_valid, 0);
        chk("rst_fill_busy", bus.fill_busy, 0);
        chk("rst_fill_done", bus.fill_done, 0);
        reset = 1'b1;
        #1;
        chk("rel_rd_ready", bus.rd_ready, 1);
        chk("rel_wr_ready", bus.wr_ready, 0);
        step();
        chk("rel_ram_re", bus.ram_re, 1);
        chk("rel_ram_we", bus.ram_we, 0);
        chk("rel_ram_addr", bus.ram_addr, 15'h0055);
        bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
        step();

        // Preload 0x0123 = 0x2A, then single read latency.
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h0123; bus.wr_data = 6'h2A;
        #1 chk("pre_wr_ready", bus.wr_ready, 1);
        step();
        bus.wr_valid = 1'b0;
        chk("pre_ram_we", bus.ram_we, 1);
        chk("pre_ram_addr", bus.ram_addr, 15'h0123);
        chk("pre_ram_din", bus.ram_din, 6'h2A);
        bus.rd_valid = 1'b1; bus.rd_addr = 15'h0123;
        #1 chk("rd1_ready", bus.rd_ready, 1);
        step();
        bus.rd_valid = 1'b0;
        chk("rd1_ram_re", bus.ram_re, 1);
        chk("rd1_ram_addr", bus.ram_addr, 15'h0123);
        step();
        chk("rd1_valid_early", bus.rd_data_valid, 0);
        step();
        chk("rd1_valid", bus.rd_data_valid, 1);
        chk("rd1_data", bus.rd_data, 6'h2A);
        step();
        chk("rd1_valid_pulse", bus.rd_data_valid, 0);

        // Table-driven priority vectors.
        bus.wr_addr = 15'h0010; bus.wr_data = 6'h15;
        foreach (vq[i]) begin
            bus.rd_valid = vq[i].rd; bus.wr_valid = vq[i].wr; bus.rd_addr = vq[i].raddr;
            #1;
            chk($sformatf("vec%0d_rd_ready", i), bus.rd_ready, vq[i].exp_rd);
            chk($sformatf("vec%0d_wr_ready", i), bus.wr_ready, vq[i].exp_wr);
            step();
            chk($sformatf("vec%0d_ram_re", i), bus.ram_re, vq[i].exp_rd);
            chk($sformatf("vec%0d_ram_we", i), bus.ram_we, vq[i].exp_wr);
            if (vq[i].exp_rd) chk($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vq[i].raddr);
            else if (vq[i].exp_wr) begin
                chk($sformatf("vec%0d_ram_addr", i), bus.ram_addr, 15'h0010);
                chk($sformatf("vec%0d_ram_din", i), bus.ram_din, 6'h15);
            end
        end
        bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
        step();

        // Fill 0x3F started together with an MCU write; a second write waits out the fill.
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h7000; bus.wr_data = 6'h11;
        bus.fill_start = 1'b1; bus.fill_color = 6'h3F;
        #1 chk("f1_concurrent_wr_ready", bus.wr_ready, 1);
        step();
        bus.fill_start = 1'b0; bus.fill_color = 6'h00;
        bus.wr_addr = 15'h7001; bus.wr_data = 6'h22;
        chk("f1_w1_ram_we", bus.ram_we, 1);
        chk("f1_w1_ram_addr", bus.ram_addr, 15'h7000);
        chk("f1_busy", bus.fill_busy, 1);
        #1 chk("f1_wr_stall", bus.wr_ready, 0);
        bad = 0;
        for (int k = 0; k <= 24191; k++) begin
            step();
            #1;
            if (!(bus.ram_we === 1'b1 && bus.ram_addr === 15'(k) && bus.ram_din === 6'h3F)) bad++;
            if (bus.fill_done !== (k == 24191)) bad++;
            if (bus.wr_ready !== (k == 24191)) bad++;
            if (bus.fill_busy !== (k != 24191)) bad++;
        end
        chk("f1_sequence_bad_cycles", bad, 0);
        step();
        bus.wr_valid = 1'b0;
        chk("f1_w2_ram_we", bus.ram_we, 1);
        chk("f1_w2_ram_addr", bus.ram_addr, 15'h7001);
        chk("f1_done_once", bus.fill_done, 0);
        step();
        step();
        mem_chk("f1_mem", 0, 24191, 6'h3F);
        chk("f1_mem_w1", mem[15'h7000], 6'h11);
        chk("f1_mem_w2", mem[15'h7001], 6'h22);

        // Fill 0x05 with a read every other cycle; reads ahead of the fill see 0x3F, behind see 0x05.
        mon_en = 1; n = 0; rdy_bad = 0; done = 0;
        bus.fill_start = 1'b1; bus.fill_color = 6'h05;
        bus.rd_valid = 1'b1; bus.rd_addr = 15'(12000);
        #1 chk("f2_start_rd_ready", bus.rd_ready, 1);
        expq.push_back(6'h3F); n++;
        step();
        bus.fill_start = 1'b0;
        cyc = 1;
        while (!done && cyc < 50000) begin
            bus.rd_valid = (cyc % 2 == 0);
            bus.rd_addr = (n < 12000) ? 15'(12000 + n) : 15'(n - 12000);
            #1;
            if (bus.rd_valid) begin
                if (bus.rd_ready !== 1'b1) rdy_bad++;
                else begin
                    expq.push_back((n < 12000) ? 6'h3F : 6'h05);
                    n++;
                end
            end
            step();
            cyc++;
            if (bus.fill_done === 1'b1) done = 1;
        end
        bus.rd_valid = 1'b0;
        chk("f2_done", done, 1);
        chk("f2_duration_ok", (cyc > 48300 && cyc < 48500), 1);
        for (int i = 0; i < 5; i++) step();
        mon_en = 0;
        chk("f2_reads_returned", rets, n);
        chk("f2_read_data_bad", rbad, 0);
        chk("f2_read_stalls", rdy_bad, 0);
        chk("f2_queue_empty", expq.size(), 0);
        mem_chk("f2_mem", 0, 24191, 6'h05);

        // Fill 0x2A aborted by reset right after address 999 is issued.
        bus.fill_start = 1'b1; bus.fill_color = 6'h2A;
        step();
        bus.fill_start = 1'b0;
        found = 0; cyc = 0;
        while (!found && cyc < 2000) begin
            if (bus.ram_we === 1'b1 && bus.ram_addr === 15'd999) found = 1;
            else begin step(); cyc++; end
        end
        chk("f3_reached_999", found, 1);
        reset = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 15'h7100; bus.wr_data = 6'h33;
        #1 chk("f3_rst_wr_ready", bus.wr_ready, 0);
        step();
        chk("f3_rst_busy", bus.fill_busy, 0);
        chk("f3_rst_ram_we", bus.ram_we, 0);
        chk("f3_rst_done", bus.fill_done, 0);
        reset = 1'b1;
        #1 chk("f3_rel_wr_ready", bus.wr_ready, 1);
        step();
        chk("f3_w_ram_we", bus.ram_we, 1);
        chk("f3_w_ram_addr", bus.ram_addr, 15'h7100);
        chk("f3_w_done", bus.fill_done, 0);
        chk("f3_w_busy", bus.fill_busy, 0);
        bus.wr_valid = 1'b0;
        step();
        chk("f3_no_done", bus.fill_done, 0);
        mem_chk("f3_mem_written", 0, 999, 6'h2A);
        mem_chk("f3_mem_untouched", 1000, 24191, 6'h05);
        chk("f3_mem_w", mem[15'h7100], 6'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
